tnkk_mac_accum_array: RTL and testbench

- Next-generation 2-bit × 4-bit select/MAC array for the conv engine.
- Multiplies Tn·K·K feature/weight pairs and reduces them through a pipelined adder tree. Accumulates the partial sums across a runtime number of input-channel tiles, adding bias on the first tile.
- Sits between the feature/weight line buffers and the output-channel post-processing (ReLU/quant), one instance per output channel (Tm instances).

---
 rtl/tnkk_mac_accum_array_pkg.sv | 18 +
 rtl/tnkk_mac_accum_array_if.sv | 29 ++
 rtl/tnkk_mac_accum_array_adder_tree.sv | 57 +++++
 rtl/tnkk_mac_accum_array.sv | 98 +++++++++
 tb/tb_tnkk_mac_accum_array.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/tnkk_mac_accum_array_pkg.sv
// tnkk_pkg: shared clog2 helper, default parameters and derived widths for the MAC accumulate array
package tnkk_pkg;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
  localparam int DEF_TN = 4;
  localparam int DEF_KERNEL_SIZE = 3;
  localparam int DEF_FEATURE_WIDTH = 4;
  localparam int DEF_KERNEL_WIDTH = 2;
  localparam int DEF_BIAS_WIDTH = 16;
  localparam int DEF_ACC_WIDTH = 32;
  localparam int N = DEF_TN * DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;
  localparam int PROD_W = DEF_FEATURE_WIDTH + DEF_KERNEL_WIDTH;
  localparam int SUM_W = PROD_W + clog2(N);
endpackage

// File: rtl/tnkk_mac_accum_array_if.sv
// tnkk_mac_accum_array_if: beat inputs (enable/valid/tile flags/features/weights/bias) and result outputs
interface tnkk_mac_accum_array_if import tnkk_pkg::*; #(
  parameter int Tn = DEF_TN,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
);
  localparam int NE = Tn * KERNEL_SIZE * KERNEL_SIZE;
  logic enable;
  logic valid_in;
  logic tile_first;
  logic tile_last;
  logic [NE*FEATURE_WIDTH-1:0] feature_in;
  logic [NE*KERNEL_WIDTH-1:0] weight_in;
  logic [BIAS_WIDTH-1:0] bias_in;
  logic [ACC_WIDTH-1:0] result;
  logic result_valid;
  logic sat_flag;
  modport master(
    output enable, valid_in, tile_first, tile_last, feature_in, weight_in, bias_in,
    input result, result_valid, sat_flag
  );
  modport slave(
    input enable, valid_in, tile_first, tile_last, feature_in, weight_in, bias_in,
    output result, result_valid, sat_flag
  );
endinterface

// File: rtl/tnkk_mac_accum_array_adder_tree.sv
// tnkk_adder_tree: pipelined pairwise adder tree, one register level per stage, with matching valid/sideband pipe
module tnkk_adder_tree import tnkk_pkg::*; #(
  parameter int NUM = N,
  parameter int IW = PROD_W,
  parameter int SBW = 1,
  parameter int LV = clog2(NUM)
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic v_i,
  input  logic [SBW-1:0] sb_i,
  input  logic [NUM*IW-1:0] d_i,
  output logic v_o,
  output logic [SBW-1:0] sb_o,
  output logic [IW+LV-1:0] sum_o
);
  genvar k, j;
  for (k = 0; k < LV; k++) begin : g_lvl
    localparam int CI = (NUM + (1 << k) - 1) >> k;
    localparam int CO = (CI + 1) / 2;
    localparam int WI = IW + k;
    logic [CI-1:0][WI-1:0] a;
    logic [CO-1:0][WI:0] s, q;
    logic pv, v_q;
    logic [SBW-1:0] psb, sb_q;
    if (k == 0) begin : g_in
      assign a = d_i;
      assign pv = v_i;
      assign psb = sb_i;
    end else begin : g_in
      assign a = g_lvl[k-1].q;
      assign pv = g_lvl[k-1].v_q;
      assign psb = g_lvl[k-1].sb_q;
    end
    for (j = 0; j < CO; j++) begin : g_add
      if (2 * j + 1 < CI) begin : g_pair
        assign s[j] = {1'b0, a[2*j]} + {1'b0, a[2*j+1]};
      end else begin : g_odd
        assign s[j] = {1'b0, a[2*j]};
      end
    end
    always_ff @(posedge clk) begin
      if (rst) v_q <= 1'b0;
      else if (en_i) v_q <= pv;
    end
    always_ff @(posedge clk) begin
      if (en_i) begin
        q <= s;
        sb_q <= psb;
      end
    end
  end
  assign sum_o = g_lvl[LV-1].q[0];
  assign v_o = g_lvl[LV-1].v_q;
  assign sb_o = g_lvl[LV-1].sb_q;
endmodule

// File: rtl/tnkk_mac_accum_array.sv
// tnkk_mac_accum_array: Tn*K*K multiply, adder tree and tile accumulator with bias; TNKK_ACC_SAT_EN selects saturating accumulate
module tnkk_mac_accum_array import tnkk_pkg::*; #(
  parameter int Tn = DEF_TN,
  parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
  parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int KERNEL_WIDTH = DEF_KERNEL_WIDTH,
  parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input logic clk,
  input logic rst,
  tnkk_mac_accum_array_if.slave bus
);
  localparam int NE = Tn * KERNEL_SIZE * KERNEL_SIZE;
  localparam int PW = FEATURE_WIDTH + KERNEL_WIDTH;
  localparam int LV = clog2(NE);
  localparam int SW = PW + LV;
  logic [NE-1:0][PW-1:0] prod_d, prod_q;
  logic v0_q, f0_q, l0_q;
  logic [BIAS_WIDTH-1:0] b0_q;
  logic t_v, t_first, t_last, hit;
  logic [BIAS_WIDTH+1:0] t_sb;
  logic [BIAS_WIDTH-1:0] t_bias;
  logic [SW-1:0] sum;
  logic [ACC_WIDTH-1:0] base, acc_new, acc_q, acc_d, res_q, res_d;
  logic rv_q, rv_d;
  genvar i;
  for (i = 0; i < NE; i++) begin : g_mul
    assign prod_d[i] = PW'(bus.feature_in[i*FEATURE_WIDTH +: FEATURE_WIDTH])
                     * PW'(bus.weight_in[i*KERNEL_WIDTH +: KERNEL_WIDTH]);
  end
  always_ff @(posedge clk) begin
    if (rst) v0_q <= 1'b0;
    else if (bus.enable) v0_q <= bus.valid_in;
  end
  always_ff @(posedge clk) begin
    if (bus.enable) begin
      prod_q <= prod_d;
      f0_q <= bus.tile_first;
      l0_q <= bus.tile_last;
      b0_q <= bus.bias_in;
    end
  end
  tnkk_adder_tree #(.NUM(NE), .IW(PW), .SBW(BIAS_WIDTH + 2)) u_tree (
    .clk(clk),
    .rst(rst),
    .en_i(bus.enable),
    .v_i(v0_q),
    .sb_i({f0_q, l0_q, b0_q}),
    .d_i(prod_q),
    .v_o(t_v),
    .sb_o(t_sb),
    .sum_o(sum)
  );
  assign t_first = t_sb[BIAS_WIDTH+1];
  assign t_last = t_sb[BIAS_WIDTH];
  assign t_bias = t_sb[BIAS_WIDTH-1:0];
`ifdef TNKK_ACC_SAT_EN
  logic [ACC_WIDTH:0] total;
  logic sat_q, sat_d;
`endif
  always_comb begin
    hit = bus.enable & t_v;
    base = t_first ? ACC_WIDTH'(t_bias) : acc_q;
`ifdef TNKK_ACC_SAT_EN
    total = (ACC_WIDTH+1)'(base) + (ACC_WIDTH+1)'(sum);
    acc_new = total[ACC_WIDTH] ? '1 : total[ACC_WIDTH-1:0];
    sat_d = sat_q | (hit & total[ACC_WIDTH]);
`else
    acc_new = base + ACC_WIDTH'(sum);
`endif
    acc_d = hit ? (t_last ? '0 : acc_new) : acc_q;
    res_d = (hit && t_last) ? acc_new : res_q;
    rv_d = hit & t_last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      res_q <= '0;
      rv_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      res_q <= res_d;
      rv_q <= rv_d;
    end
  end
`ifdef TNKK_ACC_SAT_EN
  always_ff @(posedge clk) begin
    if (rst) sat_q <= 1'b0;
    else sat_q <= sat_d;
  end
  assign bus.sat_flag = sat_q;
`else
  assign bus.sat_flag = 1'b0;
`endif
  assign bus.result = res_q;
  assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_tnkk_mac_accum_array.sv
// tb_tnkk_mac_accum_array: directed beats with a queued scoreboard checked by a monitor on the falling edge
module tb_tnkk_mac_accum_array;
  typedef struct {
    logic [31:0] res;
    logic sat;
    int cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ov_sel = 1'b0;
  logic hold_chk = 1'b0;
  logic done = 1'b0;
  int cyc = 0;
  int rst_cnt = 0;
  int checks = 0;
  int fails = 0;
  exp_t q[$];
  exp_t q12[$];
  exp_t e;
  always #5 clk = ~clk;
  tnkk_mac_accum_array_if bus();
  tnkk_mac_accum_array_if #(.ACC_WIDTH(12), .BIAS_WIDTH(8)) bus12();
  tnkk_mac_accum_array dut (.clk(clk), .rst(rst), .bus(bus));
  tnkk_mac_accum_array #(.ACC_WIDTH(12), .BIAS_WIDTH(8)) dut12 (.clk(clk), .rst(rst), .bus(bus12));
  assign bus12.enable = bus.enable;
  assign bus12.valid_in = bus.valid_in & ov_sel;
  assign bus12.tile_first = bus.tile_first;
  assign bus12.tile_last = bus.tile_last;
  assign bus12.feature_in = bus.feature_in;
  assign bus12.weight_in = bus.weight_in;
  assign bus12.bias_in = bus.bias_in[7:0];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_cnt <= rst ? rst_cnt + 1 : 0;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask
  task automatic push(input logic [31:0] r, input logic s, input int c);
    q.push_back('{res: r, sat: s, cyc: c});
  endtask
  task automatic push12(input logic [31:0] r, input logic s, input int c);
    q12.push_back('{res: r, sat: s, cyc: c});
  endtask
  task automatic beat(input logic fi, input logic la, input logic [3:0] fv, input logic [1:0] wv, input logic [15:0] bv);
    bus.enable = 1'b1;
    bus.valid_in = 1'b1;
    bus.tile_first = fi;
    bus.tile_last = la;
    bus.feature_in = {36{fv}};
    bus.weight_in = {36{wv}};
    bus.bias_in = bv;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.enable = 1'b1;
      bus.valid_in = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      bus.enable = 1'b0;
      bus.valid_in = 1'b1;
      bus.tile_first = 1'b1;
      bus.tile_last = 1'b1;
      bus.feature_in = {36{4'd9}};
      bus.weight_in = {36{2'd1}};
      bus.bias_in = 16'd500;
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      if (rst_cnt > 0) begin
        chk("rst_result", bus.result, 0);
        chk("rst_result_valid", bus.result_valid, 0);
        chk("rst_sat_flag", bus.sat_flag, 0);
        chk("rst_result12", bus12.result, 0);
      end
    end else begin
      if (hold_chk) chk("stall_result_hold", bus.result, 4870);
      if (bus.result_valid) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pulse result=%0d cycle=%0d required=no_pulse", bus.result, cyc);
        end else begin
          e = q.pop_front();
          chk("result", bus.result, e.res);
          chk("sat_flag", bus.sat_flag, e.sat);
          chk("pulse_cycle", cyc, e.cyc);
        end
      end
      if (bus12.result_valid) begin
        if (q12.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pulse12 result=%0d cycle=%0d required=no_pulse", bus12.result, cyc);
        end else begin
          e = q12.pop_front();
          chk("result12", bus12.result, e.res);
          chk("sat_flag12", bus12.sat_flag, e.sat);
          chk("pulse_cycle12", cyc, e.cyc);
        end
      end
      if (done) begin
        chk("pending_expected", q.size(), 0);
        chk("pending_expected12", q12.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
      end
    end
  end
  initial begin
    bus.enable = 1'b0;
    bus.valid_in = 1'b0;
    bus.tile_first = 1'b0;
    bus.tile_last = 1'b0;
    bus.feature_in = '0;
    bus.weight_in = '0;
    bus.bias_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    push(1630, 1'b0, cyc + 8);
    beat(1, 1, 15, 3, 10);
    idle(10);
    push(4870, 1'b0, cyc + 10);
    beat(1, 0, 15, 3, 10);
    beat(0, 0, 15, 3, 77);
    beat(0, 1, 15, 3, 77);
    idle(10);
    push(1630, 1'b0, cyc + 11);
    beat(1, 1, 15, 3, 10);
    idle(2);
    hold_chk = 1'b1;
    stall(3);
    hold_chk = 1'b0;
    idle(10);
    push(1630, 1'b0, cyc + 8);
    beat(1, 1, 15, 3, 10);
    idle(7);
    stall(2);
    idle(8);
    push(540, 1'b0, cyc + 8);
    beat(1, 1, 15, 1, 0);
    push(1080, 1'b0, cyc + 8);
    beat(1, 1, 15, 2, 0);
    idle(10);
    beat(1, 0, 15, 3, 10);
    idle(8);
    beat(0, 1, 15, 3, 10);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(2);
    push(36, 1'b0, cyc + 8);
    beat(0, 1, 1, 1, 0);
    idle(10);
    push(36, 1'b0, cyc + 8);
    beat(0, 1, 1, 1, 99);
    idle(10);
    push(41, 1'b0, cyc + 9);
    beat(1, 0, 15, 3, 10);
    beat(1, 1, 1, 1, 5);
    idle(10);
    ov_sel = 1'b1;
    push(4870, 1'b0, cyc + 10);
`ifdef TNKK_ACC_SAT_EN
    push12(4095, 1'b1, cyc + 10);
`else
    push12(774, 1'b0, cyc + 10);
`endif
    beat(1, 0, 15, 3, 10);
    beat(0, 0, 15, 3, 10);
    beat(0, 1, 15, 3, 10);
    ov_sel = 1'b0;
    idle(10);
    done = 1'b1;
    idle(20);
    $display("FAIL monitor_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
